// File: rtl/ray_dispatch_scheduler.sv
// ray_dispatch_scheduler: raster-order pixel dispatch to NUM_CORES ray cores
// with fixed core assignment (k mod N) and in-order retirement to a stream.
// Ports: clk, rst (async, active-low); start/busy/frame_done frame control;
// core_ready/core_start/x_out/y_out issue side; core_done/core_shade/core_ack
// retire side; shade_out/valid_out/ready downstream valid/ready stream.
module ray_dispatch_scheduler #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int NUM_CORES     = 4,
  parameter int OUT_WIDTH     = 24,
  localparam int XW = (SCREEN_WIDTH > 1) ? $clog2(SCREEN_WIDTH) : 1,
  localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           frame_done,
  input  logic [NUM_CORES-1:0]           core_ready,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [XW-1:0]                  x_out,
  output logic [YW-1:0]                  y_out,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES*OUT_WIDTH-1:0] core_shade,
  output logic [NUM_CORES-1:0]           core_ack,
  output logic [OUT_WIDTH-1:0]           shade_out,
  output logic                           valid_out,
  input  logic                           ready
);

  localparam int NPIX = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int PW   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [XW-1:0] X_LAST = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_HEIGHT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(NPIX - 1);
  localparam logic [CW-1:0] C_ALL  = CW'(NPIX);
  localparam logic [PW-1:0] P_LAST = PW'(NUM_CORES - 1);

  logic [1:0]           r_state;
  logic [XW-1:0]        r_x;
  logic [YW-1:0]        r_y;
  logic [CW-1:0]        r_issued;
  logic [CW-1:0]        r_retired;
  logic [PW-1:0]        r_dp;
  logic [PW-1:0]        r_rp;
  logic [NUM_CORES-1:0] r_out;
  logic [NUM_CORES-1:0] r_core_start;
  logic [XW-1:0]        r_x_out;
  logic [YW-1:0]        r_y_out;
  logic [OUT_WIDTH-1:0] r_shade;
  logic                 r_valid;
  logic                 r_done;

  logic                 w_run;
  logic                 w_active;
  logic                 w_launch;
  logic                 w_issue;
  logic                 w_retire;
  logic                 w_fin;
  logic [NUM_CORES-1:0] w_dp_hot;
  logic [NUM_CORES-1:0] w_rp_hot;
  logic [OUT_WIDTH-1:0] w_rp_shade;

  // Pointers decoded to one-hot so per-core lookups never index out of range
  // when NUM_CORES is not a power of two.
  always_comb begin
    w_dp_hot   = '0;
    w_rp_hot   = '0;
    w_rp_shade = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (r_dp == PW'(i)) w_dp_hot[i] = 1'b1;
      if (r_rp == PW'(i)) begin
        w_rp_hot[i] = 1'b1;
        w_rp_shade  = core_shade[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  assign w_run    = (r_state == S_RUN);
  assign w_active = w_run || (r_state == S_DRAIN);
  assign w_launch = (r_state == S_IDLE) && start;
  assign w_issue  = w_run && |(w_dp_hot & ~r_out & core_ready);
  // Only the core at rp may retire, which keeps output in raster order.
  assign w_retire = w_active && |(w_rp_hot & r_out & core_done)
                    && (!r_valid || ready);
  assign w_fin    = (r_state == S_DRAIN) && (r_retired == C_ALL)
                    && r_valid && ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE:
          if (start) r_state <= S_RUN;
        S_RUN:
          if (w_issue && (r_issued == C_LAST)) r_state <= S_DRAIN;
        S_DRAIN:
          if (w_fin) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        default:
          r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_issued     <= '0;
      r_dp         <= '0;
      r_core_start <= '0;
      r_x_out      <= '0;
      r_y_out      <= '0;
    end else begin
      r_core_start <= '0;
      if (w_launch) begin
        r_x      <= '0;
        r_y      <= '0;
        r_issued <= '0;
        r_dp     <= '0;
      end else if (w_issue) begin
        r_core_start <= w_dp_hot;
        r_x_out      <= r_x;
        r_y_out      <= r_y;
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
        r_dp     <= (r_dp == P_LAST) ? '0 : r_dp + PW'(1);
        r_issued <= r_issued + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rp      <= '0;
      r_retired <= '0;
      r_out     <= '0;
      r_shade   <= '0;
      r_valid   <= 1'b0;
    end else begin
      if (w_launch) begin
        r_rp      <= '0;
        r_retired <= '0;
        r_out     <= '0;
      end else begin
        // Issue and retire hit different cores, so set/clear never collide.
        r_out <= (r_out | (w_issue ? w_dp_hot : '0))
                 & ~(w_retire ? w_rp_hot : '0);
      end
      if (w_retire) begin
        r_rp      <= (r_rp == P_LAST) ? '0 : r_rp + PW'(1);
        r_retired <= r_retired + CW'(1);
        r_shade   <= w_rp_shade;
        r_valid   <= 1'b1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_done;
  assign core_start = r_core_start;
  assign x_out      = r_x_out;
  assign y_out      = r_y_out;
  assign core_ack   = w_retire ? w_rp_hot : '0;
  assign shade_out  = r_shade;
  assign valid_out  = r_valid;

endmodule

// File: tb/tb_ray_dispatch_scheduler.sv
// tb_ray_dispatch_scheduler: 4x2 frame, two modelled cores, raster-order
// reference for issue/retire/output, table-driven frames plus random runs.
module tb_ray_dispatch_scheduler;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = 2;
  localparam int OW = 8;
  localparam int NP = W * H;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            busy;
  logic            frame_done;
  logic [N-1:0]    core_ready;
  logic [N-1:0]    core_start;
  logic [1:0]      x_out;
  logic [0:0]      y_out;
  logic [N-1:0]    core_done = '0;
  logic [N*OW-1:0] core_shade = '0;
  logic [N-1:0]    core_ack;
  logic [OW-1:0]   shade_out;
  logic            valid_out;
  logic            ready = 1'b1;

  always #5 clk = ~clk;

  ray_dispatch_scheduler #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .NUM_CORES    (N),
    .OUT_WIDTH    (OW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .frame_done(frame_done),
    .core_ready(core_ready),
    .core_start(core_start),
    .x_out     (x_out),
    .y_out     (y_out),
    .core_done (core_done),
    .core_shade(core_shade),
    .core_ack  (core_ack),
    .shade_out (shade_out),
    .valid_out (valid_out),
    .ready     (ready)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Expected pixel word for raster index k: {y nibble, x nibble}.
  function automatic logic [OW-1:0] pix(input int k);
    return {4'(k / W), 4'(k % W)};
  endfunction

  // Core model state
  logic [N-1:0]  mask = '1;
  logic [N-1:0]  act = '0;
  logic [N-1:0]  ackp = '0;
  logic [N-1:0]  stp = '0;
  logic [OW-1:0] shp [N];
  int            tmr [N];
  int            lat [N];
  bit            rnd = 1'b0;

  assign core_ready = mask & ~act;

  // Reference counters
  int iss = 0, ret = 0, beat = 0, fd = 0, gcyc = 0, last_hs = -10;
  logic          pv = 1'b0, pr = 1'b0;
  logic [OW-1:0] ps = '0;
  logic [N-1:0]  e_cs, e_ack;
  logic [1:0]    e_x;
  logic [0:0]    e_y;

  always @(negedge clk) begin
    gcyc++;
    if (!rst) begin
      pv   = 1'b0;
      ackp = '0;
      stp  = '0;
    end else begin
      if (start && !busy) begin
        iss = 0; ret = 0; beat = 0; fd = 0;
      end
      if (core_start != '0) begin
        e_cs = N'(1 << (iss % N));
        e_x  = 2'(iss % W);
        e_y  = 1'(iss / W);
        chk("issue_in_frame", 64'(iss < NP), 64'd1);
        chk("issue", {core_start, x_out, y_out}, {e_cs, e_x, e_y});
        iss++;
      end
      if (core_ack != '0) begin
        e_ack = N'(1 << (ret % N));
        chk("ack", {core_ack, core_done[ret % N]}, {e_ack, 1'b1});
        ret++;
      end
      if (valid_out && !ready) chk("ack_stall", 64'(core_ack), 64'd0);
      if (pv && !pr) chk("hold", {valid_out, shade_out}, {1'b1, ps});
      if (valid_out && ready) begin
        chk("beat", shade_out, pix(beat));
        beat++;
        last_hs = gcyc;
      end
      if (frame_done) begin
        chk("frame_done", {beat == NP, busy, gcyc == last_hs + 1}, 3'b101);
        fd++;
      end
      pv = valid_out;
      pr = ready;
      ps = shade_out;
      ackp = core_ack;
      stp  = core_start;
      for (int i = 0; i < N; i++) shp[i] = {4'(y_out), 4'(x_out)};
    end
  end

  // Cores: latch the pixel at issue, raise done after the latency, hold
  // done until the ack retires it; then become idle again.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      act       = '0;
      core_done = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ackp[i]) begin
          act[i]       = 1'b0;
          core_done[i] = 1'b0;
        end
        if (stp[i]) begin
          act[i] = 1'b1;
          tmr[i] = rnd ? int'($urandom_range(6, 1)) : lat[i];
          core_shade[i*OW +: OW] = shp[i];
        end else if (act[i] && !core_done[i]) begin
          tmr[i]--;
          if (tmr[i] <= 0) core_done[i] = 1'b1;
        end
      end
    end
  end

  typedef struct {
    int lat0;
    int lat1;
    int stall_at;
    int stall_len;
    int blk_at;
    int blk_len;
    bit spur;
    bit rnd;
    int exp_beats;
    int exp_fd;
  } vec_t;

  vec_t tv [7];

  task automatic run_frame(input vec_t v);
    int  c;
    bit  pulsed;
    lat[0] = v.lat0;
    lat[1] = v.lat1;
    rnd    = v.rnd;
    pulsed = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (c = 0; c < 400 && fd == 0; c++) begin
      if (v.rnd) begin
        ready   = ($urandom % 4) != 0;
        mask[0] = ($urandom % 3) != 0;
        mask[1] = ($urandom % 3) != 0;
      end else begin
        ready   = !(c >= v.stall_at && c < v.stall_at + v.stall_len);
        mask[0] = !(c >= v.blk_at && c < v.blk_at + v.blk_len);
        mask[1] = 1'b1;
      end
      start = v.spur && (c == 4 || (!pulsed && iss == NP));
      if (iss == NP) pulsed = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    ready = 1'b1;
    mask  = '1;
    chk("frame_timeout", 64'(c < 400), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("frame_len", 64'(beat), 64'(v.exp_beats));
    chk("frame_done_cnt", 64'(fd), 64'(v.exp_fd));
    chk("issued", 64'(iss), 64'(NP));
    chk("idle_after", 64'(busy), 64'd0);
  endtask

  initial begin
    int c;
    tv[0] = '{3, 3, -1, 0, -1, 0, 1'b0, 1'b0, NP, 1};
    tv[1] = '{8, 3, -1, 0, -1, 0, 1'b0, 1'b0, NP, 1};
    tv[2] = '{3, 3,  6, 10, -1, 0, 1'b0, 1'b0, NP, 1};
    tv[3] = '{2, 2, -1, 0,  3, 6, 1'b0, 1'b0, NP, 1};
    tv[4] = '{3, 3, -1, 0, -1, 0, 1'b1, 1'b0, NP, 1};
    tv[5] = '{1, 1, -1, 0, -1, 0, 1'b0, 1'b1, NP, 1};
    tv[6] = '{1, 1, -1, 0, -1, 0, 1'b0, 1'b1, NP, 1};
    lat[0] = 3;
    lat[1] = 3;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_xy", {x_out, y_out}, 3'b000);
    chk("rst_shade", 64'(shade_out), 64'd0);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_ack", 64'(core_ack), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Start-to-first-issue latency
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_busy_c1", {busy, core_start}, 3'b100);
    @(posedge clk); #1;
    chk("first_issue_c2", {core_start, x_out, y_out}, 5'b01_00_0);
    for (c = 0; c < 300 && fd == 0; c++) begin
      @(posedge clk); #1;
    end
    chk("first_frame_done", 64'(fd), 64'd1);
    repeat (3) @(posedge clk);

    // Reset in the middle of a frame
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (c = 0; c < 300 && beat < 3; c++) begin
      @(posedge clk); #1;
    end
    chk("mid_wait", 64'(beat), 64'd3);
    rst = 1'b0;
    #1;
    chk("mid_rst_outs",
        {busy, frame_done, core_start, x_out, y_out, shade_out,
         valid_out, core_ack}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    run_frame(tv[0]);

    for (int i = 0; i < 7; i++) run_frame(tv[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ray_dispatch_scheduler.md
# ray_dispatch_scheduler

- Frame-level scheduler for the ray marcher.
- Walks the screen in raster order and hands each pixel coordinate to one of `NUM_CORES` parallel ray-march cores.
- Collects the shaded results and re-emits them strictly in raster order on a valid/ready stream.
- Sits between the frame-control registers and the downstream stream packer, which adds sof/eol framing.

## Interface

Parameters:
- `SCREEN_WIDTH`, 640: pixels per line.
- `SCREEN_HEIGHT`, 480: lines per frame.
- `NUM_CORES`, 4: number of ray-march cores; ≥1, need not be a power of 2.
- `OUT_WIDTH`, 24: shade word width.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle frame start request; honoured only in IDLE.
- `busy`  out  1: high in RUN and DRAIN.
- `frame_done`  out  1: one-cycle pulse when the last pixel of the frame is accepted downstream.
- `core_ready`  in  NUM_CORES: core i is idle and can accept a pixel.
- `core_start`  out  NUM_CORES: one-hot, one-cycle issue pulse; registered.
- `x_out`  out  $clog2(SCREEN_WIDTH): broadcast coordinate; valid while any `core_start` bit is high.
- `y_out`  out  $clog2(SCREEN_HEIGHT): broadcast coordinate; valid while any `core_start` bit is high.
- `core_done`  in  NUM_CORES: core i holds a result; held until acked.
- `core_shade`  in  NUM_CORES*OUT_WIDTH: core i result at bits [i*OUT_WIDTH +: OUT_WIDTH].
- `core_ack`  out  NUM_CORES: one-hot combinational retire strobe.
- `shade_out`  out  OUT_WIDTH: output pixel.
- `valid_out`  out  1: output valid.
- `ready`  in  1: downstream ready.

## Operation

- FSM states: IDLE, RUN, DRAIN.
  - IDLE --start--> RUN. On this edge, clear x, y, pixel counters and both pointers.
  - RUN --last pixel issued--> DRAIN.
  - DRAIN --retired count == W*H and output handshake completes--> IDLE. `frame_done` pulses on that same edge's following cycle.
  - `start` in RUN or DRAIN is ignored.
- Pixel k goes to core (k mod NUM_CORES). Dispatch pointer `dp` and retire pointer `rp` each wrap from NUM_CORES-1 to 0.
  - Fixed assignment makes in-order retirement trivial.
  - No reorder buffer is needed.
- `outstanding[NUM_CORES]` tracks which cores hold an unretired pixel.
- Issue condition: state RUN && !outstanding[dp] && core_ready[dp].
  - On issue, register core_start[dp]=1 with x_out/y_out = current x/y.
  - Set outstanding[dp].
  - Advance x: at W-1, wrap x to 0 and increment y.
  - Advance dp and increment the issued count.
  - Issuing pixel W*H-1 moves the FSM to DRAIN.
- Retire condition: state RUN or DRAIN && outstanding[rp] && core_done[rp] && (!valid_out || ready).
  - `core_ack[rp]` is high combinationally in that cycle.
  - On the edge: shade_out ← core_shade[rp], valid_out←1, clear outstanding[rp], advance rp, increment the retired count.
- Output register behaviour:
  - If valid_out && ready && no retire this cycle, valid_out←0.
  - While valid_out && !ready, shade_out is held stable.
- Simultaneous events:
  - Issue and retire in the same cycle are permitted on different cores.
  - The same core cannot be both issued and retired in one cycle, because the two outstanding conditions are mutually exclusive.
  - A core retired at edge n is issuable from cycle n+1.
- Results from a core whose outstanding bit is clear are ignored (no ack).
- Width rules:
  - Pixel counters are $clog2(W*H+1) bits.
  - x/y are compared against W-1/H-1 with equality, never overflow.
- Reset (asynchronous) forces IDLE and clears all counters, pointers, `outstanding`, `shade_out` and the strobes.
  - Reset mid-frame abandons the frame.
  - Cores share `rst`, so no stale done is retired.

## Timing

- Reset values: busy=0, frame_done=0, core_start=0, x_out=0, y_out=0, shade_out=0, valid_out=0. core_ack is 0, since all outstanding bits are 0.
- `start` sampled at edge 0 → busy=1 in cycle 1. The earliest core_start is cycle 2, issued from RUN state.
- Issue rate: at most 1 pixel/cycle across all cores.
- Retire latency: core_done high in cycle n (with ack) → valid_out high in cycle n+1.
- Sustained throughput: 1 pixel/cycle when cores and downstream keep up; an accepted output and a new retire may overlap in the same cycle.
- `frame_done` is high exactly one cycle, the cycle after the final valid_out&&ready. busy falls in that same cycle.

## Test plan

- Bench parameters: W=4, H=2, N=2, always-ready cores with 3-cycle latency, shade = {y,x}, ready=1.
  - Expected: core_start alternates 01,10 and coordinates run (0,0)…(3,1).
  - Expected: outputs 0x00,0x01,…,0x13 in order, 8 beats, then frame_done once.
- Out-of-order completion: core1 done 5 cycles before core0 → no ack to core1 until core0 retires; output order preserved.
- Backpressure: ready=0 for 10 cycles mid-frame → shade_out stable, valid_out held, no ack, dispatch stalls once both cores are outstanding. Resume gives an intact sequence.
- core_ready[0]=0 for 6 cycles → dispatch waits at dp=0 without skipping to core1.
- start pulses during RUN and DRAIN → ignored; frame length stays 8 beats.
- rst asserted after 3 retirements → all outputs at reset values immediately. A new start gives a full frame from (0,0).
